// File: rtl/muldiv_sequencer.sv
// Iterative multiply/divide unit beside the EXE-stage ALU: shift-add multiply, restoring divide,
// architectural HI/LO with MTHI/MTLO, and the pipeline stall for back-to-back HI/LO users.
//
// state | meaning
// IDLE  | HI/LO readable/writable, new operation accepted
// CALC  | one multiply/divide step per cycle, WIDTH steps
// FIX   | sign correction, HI/LO written on exit
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             mf_req,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             flush,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t             state, state_next;
  logic [CW-1:0]      counter;
  logic               div_q, neg_res, neg_rem, b_zero;
  logic [WIDTH-1:0]   mag_b, acc_hi, acc_lo;

  logic               signed_op, accept, last_step;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH:0]     mul_sum, div_shift, div_sub;
  logic [WIDTH-1:0]   step_hi, step_lo, res_hi, res_lo;
  logic [2*WIDTH-1:0] product, product_neg;

  assign signed_op = ~op[0];
  assign abs_a     = (signed_op && operand_a[WIDTH-1]) ? -operand_a : operand_a;
  assign abs_b     = (signed_op && operand_b[WIDTH-1]) ? -operand_b : operand_b;
  assign accept    = (state == IDLE) && start && !flush;
  assign last_step = (counter == CW'(WIDTH - 1));

  assign busy  = (state != IDLE);
  assign stall = busy && (start || mf_req || hi_we || lo_we);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = CALC;
      CALC: begin
        if (flush)          state_next = IDLE;
        else if (last_step) state_next = FIX;
      end
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Remainder stays below the divisor, so bit WIDTH of the difference is the borrow.
  assign mul_sum     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mag_b} : '0);
  assign div_shift   = {acc_hi, acc_lo[WIDTH-1]};
  assign div_sub     = div_shift - {1'b0, mag_b};
  assign product     = {acc_hi, acc_lo};
  assign product_neg = -product;

  always_comb begin
    step_hi = mul_sum[WIDTH:1];
    step_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
    if (div_q) begin
      step_hi = div_sub[WIDTH] ? div_shift[WIDTH-1:0] : div_sub[WIDTH-1:0];
      step_lo = {acc_lo[WIDTH-2:0], ~div_sub[WIDTH]};
    end
  end

  // Divide by zero keeps the all-ones quotient regardless of sign.
  always_comb begin
    {res_hi, res_lo} = neg_res ? product_neg : product;
    if (div_q) begin
      res_lo = (neg_res && !b_zero) ? -acc_lo : acc_lo;
      res_hi = neg_rem ? -acc_hi : acc_hi;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      counter     <= '0;
      div_q       <= 1'b0;
      neg_res     <= 1'b0;
      neg_rem     <= 1'b0;
      b_zero      <= 1'b0;
      mag_b       <= '0;
      acc_hi      <= '0;
      acc_lo      <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= '0;
      lo          <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (hi_we) hi <= wr_data;
          if (lo_we) lo <= wr_data;
          if (accept) begin
            div_q       <= op[1];
            neg_res     <= signed_op && (operand_a[WIDTH-1] ^ operand_b[WIDTH-1]);
            neg_rem     <= signed_op && op[1] && operand_a[WIDTH-1];
            b_zero      <= (operand_b == '0);
            mag_b       <= abs_b;
            acc_hi      <= '0;
            acc_lo      <= abs_a;
            counter     <= '0;
            div_by_zero <= 1'b0;
          end
        end
        CALC: begin
          if (!flush) begin
            acc_hi  <= step_hi;
            acc_lo  <= step_lo;
            counter <= counter + CW'(1);
          end
        end
        FIX: begin
          if (!flush) begin
            hi   <= res_hi;
            lo   <= res_lo;
            done <= 1'b1;
            if (div_q && b_zero) div_by_zero <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
